uart_receiver: RTL

- 8N1 UART receive block; the receive half of the team's UART alongside the existing 8N1 transmitter, same baud convention (100 MHz clock, 115.2 kbps).
- Oversamples the asynchronous serial line, qualifies the start bit at mid-bit, samples 8 data bits LSB-first plus one stop bit, and presents each byte in a holding register with a valid/read-enable handshake.
- Flags framing errors and overruns with sticky bits; the CPU-side UART wrapper reads them.

---
 rtl/uart_receiver.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start qualification, LSB-first
// data sampling, and a holding register with valid/re handshake and sticky error flags.
module uart_receiver #(
  parameter int WAIT_DIV = 868,
  parameter int WAIT_LEN = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       re,
  input  logic       err_clr,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [WAIT_LEN-1:0] HALF_M1 = WAIT_LEN'(WAIT_DIV / 2 - 1);
  localparam logic [WAIT_LEN-1:0] DIV_M1  = WAIT_LEN'(WAIT_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_LEN-1:0] wait_q, wait_d;
  logic [3:0]          bit_q, bit_d;
  logic [7:0]          shreg_q, shreg_d;
  logic                rx_meta, rx_s;
  logic                done, ferr_set;

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep the two flops as a true two-stage pipeline.
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    wait_d   = wait_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    done     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          wait_d  = '0;
        end
      end
      S_START: begin
        if (wait_q == HALF_M1) begin
          wait_d  = '0;
          bit_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          wait_d = wait_q + WAIT_LEN'(1);
        end
      end
      S_DATA: begin
        if (wait_q == DIV_M1) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          wait_d  = '0;
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd7) state_d = S_STOP;
        end else begin
          wait_d = wait_q + WAIT_LEN'(1);
        end
      end
      S_STOP: begin
        if (wait_q == DIV_M1) begin
          wait_d = '0;
          if (rx_s) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          wait_d = wait_q + WAIT_LEN'(1);
        end
      end
      S_BREAK: begin
        // A held-low line must go high before another start can be recognised.
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (done) data_out <= shreg_q;

      if (done)    valid <= 1'b1;
      else if (re) valid <= 1'b0;

      // A completing byte only overruns when the held one is neither read nor empty.
      if (done && valid && !re) overrun <= 1'b1;
      else if (err_clr)         overrun <= 1'b0;

      if (ferr_set)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule
